// File: rtl/four_bit_addsub_arbiter_pkg.sv
// Shared constants and types for the two-requester 4-bit add/sub arbiter.
// Imported by the interface, the datapath and the top level.
package four_bit_addsub_arbiter_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
  } addsub_res_t;

endpackage

// File: rtl/four_bit_addsub_arbiter_if.sv
// Bundle of requester, grant and result-handshake signals for the arbiter.
// master = operand sources plus result consumer, slave = the arbiter.
interface four_bit_addsub_arbiter_if;
  import four_bit_addsub_arbiter_pkg::*;

  logic             req_0;
  logic [WIDTH-1:0] a_0;
  logic [WIDTH-1:0] b_0;
  logic             sub_0;
  logic             req_1;
  logic [WIDTH-1:0] a_1;
  logic [WIDTH-1:0] b_1;
  logic             sub_1;
  logic             gnt_0;
  logic             gnt_1;
  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output req_0, a_0, b_0, sub_0,
    output req_1, a_1, b_1, sub_1,
    output res_ready,
    input  gnt_0, gnt_1,
    input  res_valid, res_id, result, carry_out, overflow
  );

  modport slave (
    input  req_0, a_0, b_0, sub_0,
    input  req_1, a_1, b_1, sub_1,
    input  res_ready,
    output gnt_0, gnt_1,
    output res_valid, res_id, result, carry_out, overflow
  );

endinterface

// File: rtl/four_bit_2x1_mux.sv
// Plain 4-bit 2:1 multiplexer used for operand routing.
module four_bit_2x1_mux (
  input  logic [3:0] i_d0,
  input  logic [3:0] i_d1,
  input  logic       i_sel,
  output logic [3:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/four_bit_addsub.sv
// Combinational 4-bit adder/subtractor: A + (Sub ? ~B : B) + Sub.
// Carry out is "no borrow" when subtracting.
module four_bit_addsub
  import four_bit_addsub_arbiter_pkg::*;
(
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry_out,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;

  assign w_b_eff = i_sub ? ~i_b : i_b;
  assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};

  assign o_result    = w_sum[WIDTH-1:0];
  assign o_carry_out = w_sum[WIDTH];
  // Signed overflow: same-sign effective operands producing an opposite-sign result
  assign o_overflow  = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/four_bit_addsub_arbiter.sv
// Round-robin arbiter sharing one registered 4-bit add/sub stage between two
// requesters; the tagged result is held under a valid/ready handshake.
module four_bit_addsub_arbiter #(
  parameter int   WIDTH          = 4,    // only 4 is supported
  parameter logic FIRST_PRIORITY = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  four_bit_addsub_arbiter_if.slave  bus
);
  import four_bit_addsub_arbiter_pkg::*;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_last_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic             r_id;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_res_id;
  logic             r_res_valid;

  logic             w_any_req;
  logic             w_win_id;
  logic             w_grant;
  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_b_sel;
  logic [WIDTH-1:0] w_sub_sel;
  logic [WIDTH-1:0] w_result;
  logic             w_carry_out;
  logic             w_overflow;

  // Round-robin: on a tie the requester that did not win last time goes first
  always_comb begin
    w_any_req = bus.req_0 | bus.req_1;
    if (bus.req_0 && bus.req_1) begin
      w_win_id = ~r_last_id;
    end else if (bus.req_1) begin
      w_win_id = ID_REQ1;
    end else begin
      w_win_id = ID_REQ0;
    end
  end

  four_bit_2x1_mux u_mux_a (
    .i_d0  (bus.a_0),
    .i_d1  (bus.a_1),
    .i_sel (w_win_id),
    .o_y   (w_a_sel)
  );

  four_bit_2x1_mux u_mux_b (
    .i_d0  (bus.b_0),
    .i_d1  (bus.b_1),
    .i_sel (w_win_id),
    .o_y   (w_b_sel)
  );

  four_bit_2x1_mux u_mux_sub (
    .i_d0  ({3'b000, bus.sub_0}),
    .i_d1  ({3'b000, bus.sub_1}),
    .i_sel (w_win_id),
    .o_y   (w_sub_sel)
  );

  four_bit_addsub u_addsub (
    .i_a         (r_a),
    .i_b         (r_b),
    .i_sub       (r_sub),
    .o_result    (w_result),
    .o_carry_out (w_carry_out),
    .o_overflow  (w_overflow)
  );

  // Grant is masked during reset so no pulse appears while Reset_n is low
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req && i_rst_n) begin
          w_grant      = 1'b1;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_id <= ~FIRST_PRIORITY;
      r_a       <= '0;
      r_b       <= '0;
      r_sub     <= 1'b0;
      r_id      <= 1'b0;
    end else if (w_grant) begin
      r_last_id <= w_win_id;
      r_a       <= w_a_sel;
      r_b       <= w_b_sel;
      r_sub     <= w_sub_sel[0];
      r_id      <= w_win_id;
    end
  end

  // Result registers keep their last value after the consumer takes it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_valid <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_result    <= w_result;
      r_carry_out <= w_carry_out;
      r_overflow  <= w_overflow;
      r_res_id    <= r_id;
      r_res_valid <= 1'b1;
    end else if ((r_state == ST_DONE) && bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.gnt_0     = w_grant && (w_win_id == ID_REQ0);
  assign bus.gnt_1     = w_grant && (w_win_id == ID_REQ1);
  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_four_bit_addsub_arbiter.sv
// Self-checking bench: directed reset/arbitration/backpressure sequences, a
// table of arithmetic vectors, then randomized traffic against a reference model.
module tb_four_bit_addsub_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  four_bit_addsub_arbiter_if bus();

  four_bit_addsub_arbiter #(.WIDTH(4), .FIRST_PRIORITY(1'b0)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
    logic [3:0] res;
    logic       c;
    logic       v;
  } vec_t;

  vec_t vt[10];

  // random-phase model state
  bit         pend[2];
  logic [3:0] pa[2];
  logic [3:0] pb[2];
  logic       ps[2];
  bit         busy;
  int         age;
  logic       last;
  logic [5:0] exp_r;
  logic       exp_id;
  logic       eg0, eg1, win, ev;
  logic [6:0] got;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // {result, carry_out, overflow} from unsigned/signed integer arithmetic
  function automatic logic [5:0] ref_op(input logic [3:0] a, input logic [3:0] b, input logic sub);
    int ua, ub, sa, sb, u, s;
    logic [3:0] r;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = a[3] ? ua - 16 : ua;
    sb = b[3] ? ub - 16 : ub;
    u  = sub ? ua - ub + 16 : ua + ub;
    s  = sub ? sa - sb : sa + sb;
    r  = u[3:0];
    c  = (u >= 16);
    v  = (s > 7) || (s < -8);
    return {r, c, v};
  endfunction

  function automatic logic [15:0] outs_all();
    return 16'({bus.gnt_0, bus.gnt_1, bus.res_valid, bus.res_id,
                bus.result, bus.carry_out, bus.overflow});
  endfunction

  function automatic logic [15:0] res_tag();
    return 16'({bus.result, bus.carry_out, bus.overflow, bus.res_id});
  endfunction

  function automatic logic [15:0] gnts();
    return 16'({bus.gnt_1, bus.gnt_0});
  endfunction

  task automatic do_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                       input logic sub, output logic [6:0] res);
    int n;
    @(negedge clk);
    bus.res_ready = 1'b0;
    if (id) begin
      bus.req_1 = 1'b1; bus.a_1 = a; bus.b_1 = b; bus.sub_1 = sub;
    end else begin
      bus.req_0 = 1'b1; bus.a_0 = a; bus.b_0 = b; bus.sub_0 = sub;
    end
    n = 0;
    #1;
    while (((id ? bus.gnt_1 : bus.gnt_0) !== 1'b1) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("op_gnt_seen", 16'(n < 20), 16'd1);
    @(negedge clk);
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    #1;
    chk("op_valid_early", 16'(bus.res_valid), 16'd0);
    @(negedge clk); #1;
    chk("op_valid_latency", 16'(bus.res_valid), 16'd1);
    res = {bus.result, bus.carry_out, bus.overflow, bus.res_id};
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    chk("op_consumed", 16'(bus.res_valid), 16'd0);
  endtask

  initial begin
    vt[0] = '{1'b0, 4'd7, 4'd5, 1'b0, 4'hC, 1'b0, 1'b1};
    vt[1] = '{1'b1, 4'd0, 4'd1, 1'b1, 4'hF, 1'b0, 1'b0};
    vt[2] = '{1'b0, 4'd8, 4'd1, 1'b1, 4'h7, 1'b1, 1'b1};
    vt[3] = '{1'b1, 4'd5, 4'd5, 1'b1, 4'h0, 1'b1, 1'b0};
    vt[4] = '{1'b0, 4'hF, 4'd1, 1'b0, 4'h0, 1'b1, 1'b0};
    vt[5] = '{1'b1, 4'd8, 4'd8, 1'b0, 4'h0, 1'b1, 1'b1};
    vt[6] = '{1'b0, 4'd7, 4'd8, 1'b1, 4'hF, 1'b0, 1'b1};
    vt[7] = '{1'b1, 4'd9, 4'd3, 1'b1, 4'h6, 1'b1, 1'b1};
    vt[8] = '{1'b0, 4'd3, 4'd1, 1'b1, 4'h2, 1'b1, 1'b0};
    vt[9] = '{1'b1, 4'd2, 4'd2, 1'b0, 4'h4, 1'b0, 1'b0};

    // Reset with both requesters pending
    rst_n = 1'b0;
    bus.res_ready = 1'b0;
    bus.req_0 = 1'b1; bus.a_0 = 4'd3; bus.b_0 = 4'd1; bus.sub_0 = 1'b1;
    bus.req_1 = 1'b1; bus.a_1 = 4'd2; bus.b_1 = 4'd2; bus.sub_1 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", outs_all(), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_tie_gnt0", gnts(), 16'b01);
    @(negedge clk);
    bus.req_0 = 1'b0;
    #1;
    chk("exec_no_valid", 16'(bus.res_valid), 16'd0);
    chk("exec_no_gnt", gnts(), 16'd0);
    @(negedge clk); #1;
    chk("op0_valid", 16'(bus.res_valid), 16'd1);
    chk("op0_3m1", res_tag(), 16'({4'd2, 1'b1, 1'b0, 1'b0}));
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    chk("op0_consumed", 16'(bus.res_valid), 16'd0);
    chk("rr_gnt1", gnts(), 16'b10);
    @(negedge clk);
    bus.req_1 = 1'b0;
    @(negedge clk); #1;
    chk("op1_2p2", res_tag(), 16'({4'd4, 1'b0, 1'b0, 1'b1}));

    // Backpressure in DONE with requester 1 waiting
    bus.req_1 = 1'b1; bus.a_1 = 4'd9; bus.b_1 = 4'd3; bus.sub_1 = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      chk("bp_valid", 16'(bus.res_valid), 16'd1);
      chk("bp_hold", res_tag(), 16'({4'd4, 1'b0, 1'b0, 1'b1}));
      chk("bp_no_gnt", gnts(), 16'd0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    chk("bp_released", 16'(bus.res_valid), 16'd0);
    chk("bp_gnt1", gnts(), 16'b10);
    @(negedge clk);
    bus.req_1 = 1'b0;
    @(negedge clk); #1;
    chk("op2_9m3", res_tag(), 16'({4'd6, 1'b1, 1'b1, 1'b1}));
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;

    // Requester 0 last won here, so a tie would go to 1 unless reset restores priority
    bus.req_0 = 1'b1; bus.a_0 = 4'd8; bus.b_0 = 4'd1; bus.sub_0 = 1'b1;
    #1;
    chk("abort_gnt0", gnts(), 16'b01);
    @(negedge clk);
    bus.req_0 = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_clear", outs_all(), 16'd0);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("abort_no_valid", 16'(bus.res_valid), 16'd0);
    end
    bus.req_0 = 1'b1;
    bus.req_1 = 1'b1;
    #1;
    chk("post_reset_tie_gnt0", gnts(), 16'b01);
    @(negedge clk);
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.res_ready = 1'b0;

    // Table of arithmetic vectors, one requester at a time
    for (int i = 0; i < 10; i++) begin
      do_op(vt[i].id, vt[i].a, vt[i].b, vt[i].sub, got);
      chk($sformatf("vec%0d", i), 16'(got),
          16'({vt[i].res, vt[i].c, vt[i].v, vt[i].id}));
    end

    // Randomized traffic from a clean reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    busy = 1'b0; age = 0; last = 1'b1;
    exp_r = '0; exp_id = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          pa[r] = 4'($urandom);
          pb[r] = 4'($urandom);
          ps[r] = 1'($urandom);
        end
      end
      bus.req_0 = pend[0]; bus.a_0 = pa[0]; bus.b_0 = pb[0]; bus.sub_0 = ps[0];
      bus.req_1 = pend[1]; bus.a_1 = pa[1]; bus.b_1 = pb[1]; bus.sub_1 = ps[1];
      bus.res_ready = ($urandom_range(0, 3) != 0);
      #1;
      eg0 = 1'b0; eg1 = 1'b0; win = 1'b0;
      if (!busy && (pend[0] || pend[1])) begin
        win = (pend[0] && pend[1]) ? ~last : pend[1];
        eg0 = ~win;
        eg1 = win;
      end
      if (busy) age++;
      ev = busy && (age >= 2);
      chk("rnd_gnt", gnts(), 16'({eg1, eg0}));
      chk("rnd_valid", 16'(bus.res_valid), 16'(ev));
      if (ev) chk("rnd_result", res_tag(), 16'({exp_r, exp_id}));
      if (ev && bus.res_ready) busy = 1'b0;
      if (eg0 || eg1) begin
        busy = 1'b1;
        age = 0;
        exp_r = ref_op(pa[win], pb[win], ps[win]);
        exp_id = win;
        last = win;
        pend[win] = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/four_bit_addsub_arbiter.md
Name: four_bit_addsub_arbiter

Overview:
Shares one 4-bit adder/subtractor datapath between two requesters.
- Round-robin arbitration picks one requester; its operands and mode are routed through 2:1 operand muxes into a registered add/sub stage.
- The tagged result is held under a valid/ready handshake until the consumer accepts it.
- Sits between the two operand sources and the result consumer in the adder/subtractor subsystem.

Parameters:
WIDTH, 4, operand/result width; only 4 is supported.
FIRST_PRIORITY, 0, requester that wins the first tie after reset.

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous active-low reset
Req_0  input  1  requester 0 has an operation pending
A_0  input  4  requester 0 operand A
B_0  input  4  requester 0 operand B
Sub_0  input  1  requester 0 mode: 1 = A-B, 0 = A+B
Req_1  input  1  requester 1 request
A_1  input  4  requester 1 operand A
B_1  input  4  requester 1 operand B
Sub_1  input  1  requester 1 mode
Gnt_0  output  1  one-cycle pulse: requester 0 operation accepted this edge
Gnt_1  output  1  one-cycle pulse: requester 1 operation accepted this edge
Res_Valid  output  1  result registers hold an unconsumed result
Res_Ready  input  1  consumer accepts the result
Res_Id  output  1  requester that owns the result
Result  output  4  sum/difference, modulo 16
Carry_Out  output  1  carry out of bit 3; for subtract, 1 = no borrow
Overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset (async, Reset_n=0):
  - State=IDLE.
  - Gnt_0, Gnt_1, Res_Valid, Res_Id, Result, Carry_Out and Overflow are all 0.
  - Last_Id = ~FIRST_PRIORITY.
  - Any in-flight operation is discarded; no result is emitted for it.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If any Req is high, grant the winner: Gnt_x=1 combinationally in that cycle.
  - On that edge, capture the selected A, B, Sub and Id into operand registers; Last_Id takes the winner's Id; go to EXEC.
  - If no Req is high: stay in IDLE, both Gnt outputs 0.
- Arbitration:
  - Only one Req high: that requester wins.
  - Both high: requester ~Last_Id wins.
  - Gnt_0 and Gnt_1 are never high together.
- EXEC:
  - The datapath computes A + (Sub ? ~B : B) + Sub on the captured operands.
  - Result, Carry_Out, Overflow and Res_Id are registered on the edge; go to DONE.
- DONE:
  - Res_Valid=1. Result, Carry_Out, Overflow and Res_Id stay stable while Res_Ready=0.
  - When Res_Ready=1, clear Res_Valid on the edge and go to IDLE. Result registers keep their last value.
- Latency and throughput:
  - Grant edge T; Res_Valid rises after edge T+1.
  - Minimum of 3 cycles per operation. No grant is issued outside IDLE.
- Overflow rule: set when the effective operands (A, and B or ~B) share a sign bit and Result's sign bit differs from it.
- Requester obligations: hold Req and operands stable until Gnt is seen. A Req dropped before its grant is not served and has no effect on Last_Id.
- Req inputs seen during EXEC or DONE are ignored until IDLE.
- Res_Ready asserted while Res_Valid=0 is ignored.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, EXEC=2'd1, DONE=2'd2);
  - ID_REQ0 and ID_REQ1;
  - the WIDTH constant.
- Operand selection uses three instances of the existing four_bit_2x1_mux (A, B, and Sub padded), with Select driven by the winner Id.
- One natural sub-module: four_bit_addsub, the combinational adder/subtractor producing Result, Carry_Out and Overflow.

Test Plan:
1. Reset_n=0 with Req_0=Req_1=1 → all outputs 0, no Gnt. Release → first grant goes to requester 0 (FIRST_PRIORITY=0).
2. Req_0 only, A_0=7, B_0=5, Sub_0=0, Res_Ready=1 → Gnt_0 pulse at T; Res_Valid from T+2; Result=4'hC, Carry_Out=0, Overflow=1, Res_Id=0.
3. Both Req high from reset, with requester 0 doing 3-1 and requester 1 doing 2+2:
   - first grant to 0: Result=2, Carry_Out=1, Overflow=0;
   - next grant to 1: Result=4, Carry_Out=0, Res_Id=1.
4. Backpressure: Res_Ready=0 for 5 cycles in DONE with Req_1 high → Res_Valid and Result stable, no Gnt. Ready=1 → Res_Valid falls, Gnt_1 in the next IDLE cycle.
5. Subtract edges:
   - 0-1 → Result=4'hF, Carry_Out=0, Overflow=0.
   - 8-1 → Result=7, Carry_Out=1, Overflow=1.
   - 5-5 → Result=0, Carry_Out=1.
6. Reset_n pulsed low during EXEC → outputs clear immediately and no Res_Valid appears for the aborted op. After release with both Req high, requester 0 wins.
